// File: rtl/alu32_pkg.sv
// Shared ALU32 definitions: operand widths and the sequential shifter state encoding.
package alu32_pkg;
  localparam int ALU_W   = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGES  = SHAMT_W;
  localparam int K_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/seq_rshifter32_if.sv
// Operand/result bundle of the sequential right shifter; clk and rst stay outside.
interface seq_rshifter32_if;
  import alu32_pkg::*;

  logic [ALU_W-1:0] in1;
  logic [ALU_W-1:0] in2;
  logic             arith;
  logic             start;
  logic             enable;
  logic             busy;
  logic             done;
  logic [ALU_W-1:0] out;

  modport master (output in1, in2, arith, start, enable, input busy, done, out);
  modport slave  (input in1, in2, arith, start, enable, output busy, done, out);
endinterface

// File: rtl/rshift_stage.sv
// One binary right-shift stage: shifts by 2^k when en is set, filling from the top with fill.
module rshift_stage
  import alu32_pkg::*;
(
  input  logic [ALU_W-1:0] in,
  input  logic             fill,
  input  logic             en,
  input  logic [K_W-1:0]   k,
  output logic [ALU_W-1:0] out
);
  logic [STAGES-1:0]             dec;
  logic [ALU_W-1:0][STAGES-1:0]  pick;
  logic [ALU_W-1:0]              sel;

  genvar gi, gj;
  generate
    for (gj = 0; gj < STAGES; gj++) begin : g_dec
      assign dec[gj] = (k == K_W'(gj));
    end

    // Each output bit ORs the candidate source bits, one per stage distance, masked by the decoded k.
    for (gi = 0; gi < ALU_W; gi++) begin : g_bit
      for (gj = 0; gj < STAGES; gj++) begin : g_dist
        if (gi + (1 << gj) < ALU_W) begin : g_src
          assign pick[gi][gj] = dec[gj] & in[gi + (1 << gj)];
        end else begin : g_fill
          assign pick[gi][gj] = dec[gj] & fill;
        end
      end
      assign sel[gi] = |pick[gi];
      assign out[gi] = (en & sel[gi]) | (~en & in[gi]);
    end
  endgenerate
endmodule

// File: rtl/seq_rshifter32.sv
// Multi-cycle 32-bit logical/arithmetic right shifter resolving one power-of-two stage per clock.
module seq_rshifter32
  import alu32_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  seq_rshifter32_if.slave    ifc
);
  state_t             state_reg, state_next;
  logic [K_W-1:0]     k_reg, k_next;
  logic [ALU_W-1:0]   work_reg, work_next;
  logic [ALU_W-1:0]   result_reg, result_next;
  logic [SHAMT_W-1:0] amt_reg, amt_next;
  logic               fill_reg, fill_next;
  logic [ALU_W-1:0]   stage_out;

  rshift_stage u_stage (
    .in   (work_reg),
    .fill (fill_reg),
    .en   (amt_reg[k_reg]),
    .k    (k_reg),
    .out  (stage_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      k_reg      <= '0;
      work_reg   <= '0;
      result_reg <= '0;
      amt_reg    <= '0;
      fill_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      work_reg   <= work_next;
      result_reg <= result_next;
      amt_reg    <= amt_next;
      fill_reg   <= fill_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    work_next   = work_reg;
    result_next = result_reg;
    amt_next    = amt_reg;
    fill_next   = fill_reg;

    unique case (state_reg)
      IDLE, DONE: begin
        if (ifc.start) begin
          // Sign fill is resolved here so the stages never need Arith again.
          work_next  = ifc.in1;
          amt_next   = ifc.in2[SHAMT_W-1:0];
          fill_next  = ifc.arith & ifc.in1[ALU_W-1];
          k_next     = '0;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        work_next = stage_out;
        if (k_reg == K_W'(STAGES - 1)) begin
          result_next = stage_out;
          state_next  = DONE;
        end else begin
          k_next = k_reg + K_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ifc.busy = (state_reg == SHIFT);
  assign ifc.done = (state_reg == DONE);

  genvar gi;
  generate
    for (gi = 0; gi < ALU_W; gi++) begin : g_gate
      assign ifc.out[gi] = result_reg[gi] & ifc.enable;
    end
  endgenerate
endmodule

// File: doc/seq_rshifter32.md
# seq_rshifter32

Multi-cycle 32-bit right shifter (logical or arithmetic). It is the right-direction counterpart to the ALU's combinational left shifter and shares that shifter's operand conventions: In1 is the data, In2[4:0] is the shift amount, and Out is gated by Enable. It resolves one binary shift stage (1, 2, 4, 8, 16) per clock under a Start/Done handshake, trading latency for area. It sits in the ALU32 shifter path next to the left shifter.

## Interface
- WIDTH, 32, data width; fixed at 32.
- STAGES, 5, log2(WIDTH); number of shift stages.

- Clk  in  1  single clock; everything is on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- In1  in  32  data operand; sampled only on an accepted Start.
- In2  in  32  shift amount; only [4:0] is used and [31:5] is ignored; sampled on an accepted Start.
- Arith  in  1  0 selects logical shift (zero fill); 1 selects arithmetic shift (sign fill from latched In1[31]); sampled on an accepted Start.
- Start  in  1  request; accepted only in IDLE or DONE.
- Enable  in  1  output gate, high as enable. Combinational AND onto Out.
- Busy  out  1  high in SHIFT.
- Done  out  1  one-cycle pulse when the result register updates.
- Out  out  32  result register AND Enable (bitwise).

## Operation
- States:
  - IDLE: Busy=0, Done=0.
  - SHIFT: Busy=1, stage counter k runs 0..4.
  - DONE: Done=1 for exactly one cycle.
- IDLE or DONE with Start=1: latch In1 into the work register, latch In2[4:0] into amt, latch Arith and the fill bit (Arith & In1[31]). Set k=0 and go to SHIFT.
- DONE with Start=0: go to IDLE.
- SHIFT, each cycle:
  - If amt[k]=1, the work register shifts right by 2^k, filling from the top with the fill bit. Otherwise it is unchanged.
  - If k=4, the result register takes the stage output and the state goes to DONE. Otherwise k increments.
- Start in SHIFT is ignored; it is neither queued nor allowed to corrupt the latched operands.
- The result register holds its value through IDLE, DONE and the next SHIFT. It changes only on the k=4 edge.
- Out = result & {32{Enable}}. Done and Busy are not gated by Enable.
- Amount 0: the result equals the latched In1 and latency is unchanged (no early exit).
- Rst=1 at any edge, including mid-SHIFT:
  - state returns to IDLE.
  - the work register, result register, amt, k and fill are all cleared.
  - no Done is produced for the aborted operation.
  - Rst takes priority over Start on the same edge.

## Timing
- Reset values: Busy=0, Done=0, Out=0.
- Start accepted at edge t0. SHIFT stages execute at edges t1..t5. After t5, Done=1 and Out is valid. At t6 the state returns to IDLE, or re-enters SHIFT if Start=1.
- Latency from Start to Done is 6 cycles. Busy is high for the 5 cycles between t0 and t5.
- Back-to-back throughput is one result per 6 cycles: Start held in the Done cycle is accepted at t6.
- Enable-to-Out is a combinational path with no register.

## Structure
- Shared package (alu32_pkg) holds:
  - ALU_W = 32 and SHAMT_W = 5.
  - the state typedef {IDLE, SHIFT, DONE}.
- One sub-module, rshift_stage. It takes in[31:0], fill, en and k[2:0], and produces out = en ? {fill×2^k, in[31:2^k]} : in, with k decoded to 1/2/4/8/16. It is combinational and built from a gate-level mux per bit, matching the ALU32_GATE style.
- Top level contains the FSM, the counter, the operand/result registers and the Enable AND array.

## Test plan
- Logical full shift: In1=0x80000000, In2=31, Arith=0, one-cycle Start → Busy high 5 cycles, Done pulse 6 cycles after Start, Out=0x00000001 while Enable=1.
- Arithmetic shift: In1=0x80000000, In2=4, Arith=1 → Out=0xF8000000. Repeat with In1=0x7FFFFFF0 → Out=0x07FFFFFF.
- Upper amount bits ignored and zero shift:
  - In1=0xFFFFFFFF, In2=0x00000025, Arith=0 → Out=0x07FFFFFF.
  - In2=0 → Out=In1, still with 6-cycle latency.
- Start during Busy: second Start with In1=0x12345678 at cycle t2 → exactly one Done, with the first operation's result. Then a Start in the Done cycle is accepted, and its Done arrives 6 cycles later.
- Reset mid-operation: Rst at t3 → next cycle Busy=0, Done=0, Out=0, and no Done is seen afterwards. A fresh Start then completes normally.
- Enable gating: Enable=0 during the operation → Done still pulses and Out=0. Raising Enable later shows the held result; In1/In2 changes after Start have no effect on it.
